// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// serial_subtractor_pkg : FSM state encoding and slice-geometry helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_num_slices(input int size, input int slice);
        return (size + slice - 1) / slice;
    endfunction

    // Index width for a counter/selector over n positions, never narrower than 1.
    function automatic int calc_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// ============================================================================
// full_subtractor : single-bit difference/borrow cell
// Revision 1.0
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : D = A - B - Bin over SIZE bits, SLICE bits per clock
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int SIZE  = 511,
    parameter int SLICE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            Bin,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] D,
    output logic            Bout
);

    localparam int NUM_SLICES = calc_num_slices(SIZE, SLICE);
    localparam int KW         = calc_idx_width(NUM_SLICES);
    localparam int PAD        = NUM_SLICES * SLICE;
    localparam int PW         = calc_idx_width(PAD);
    localparam int LAST_W     = SIZE - (NUM_SLICES - 1) * SLICE;
    localparam logic [KW-1:0] C_LAST_K = KW'(NUM_SLICES - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [KW-1:0]     r_k;
    logic [SIZE-1:0]   r_a;
    logic [SIZE-1:0]   r_b;
    logic [SIZE-1:0]   r_d;
    logic              r_borrow;
    logic              r_bout;

    logic [PAD-1:0]    w_a_pad;
    logic [PAD-1:0]    w_b_pad;
    logic [PW-1:0]     w_base;
    logic [SLICE-1:0]  w_a_slice;
    logic [SLICE-1:0]  w_b_slice;
    logic [SLICE-1:0]  w_d_slice;
    logic [SLICE:0]    w_chain;
    logic [SIZE-1:0]   w_d_next;
    logic              w_last;
    logic              w_bout;
    logic              w_busy;
    logic              w_done;

    // Zero padding above SIZE keeps the part-select in range on the last slice.
    generate
        if (PAD > SIZE) begin : g_pad
            assign w_a_pad = {{(PAD - SIZE){1'b0}}, r_a};
            assign w_b_pad = {{(PAD - SIZE){1'b0}}, r_b};
        end else begin : g_nopad
            assign w_a_pad = r_a;
            assign w_b_pad = r_b;
        end
    endgenerate

    assign w_base    = PW'(int'(r_k) * SLICE);
    assign w_a_slice = w_a_pad[w_base +: SLICE];
    assign w_b_slice = w_b_pad[w_base +: SLICE];
    assign w_chain[0] = r_borrow;

    generate
        for (genvar j = 0; j < SLICE; j++) begin : g_lane
            full_subtractor u_fs (
                .a    (w_a_slice[j]),
                .b    (w_b_slice[j]),
                .bin  (w_chain[j]),
                .d    (w_d_slice[j]),
                .bout (w_chain[j+1])
            );
        end
    endgenerate

    assign w_last = (r_k == C_LAST_K);
    // The partial last slice takes its borrow from bit SIZE-1, not the padded top lane.
    assign w_bout = w_last ? w_chain[LAST_W] : w_chain[SLICE];

    generate
        for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
            localparam int LO = s * SLICE;
            localparam int W  = ((SIZE - LO) < SLICE) ? (SIZE - LO) : SLICE;
            assign w_d_next[LO +: W] = ((r_state == ST_RUN) && (r_k == KW'(s)))
                                       ? w_d_slice[W-1:0] : r_d[LO +: W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
        end else begin
            r_d <= w_d_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= Bin;
                        r_k      <= '0;
                    end
                end
                ST_RUN: begin
                    r_borrow <= w_bout;
                    if (w_last) begin
                        r_bout <= w_bout;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = w_busy;
    assign done = w_done;
    assign D    = r_d;
    assign Bout = r_bout;

endmodule

`default_nettype wire
